window_shade_actuator: RTL and testbench
========================================

WINDOW_SHADE_ACTUATOR -- requirements
Module: window_shade_actuator

Interface
REQ-001 SHALL have parameter STEP_CYCLES, default 1000, clock cycles the motor runs per one shade level.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, motor-off dead time, in cycles, before a direction reversal.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wshade  input  4  requested shade level (0 = open, 15 = closed).
REQ-006 SHALL have port wshade_valid  input  1  wshade qualifier.
REQ-007 SHALL have port wshade_ready  output  1  block accepts a request this cycle.
REQ-008 SHALL have port limit_top  input  1  closed-end limit switch, active-high.
REQ-009 SHALL have port limit_bottom  input  1  open-end limit switch, active-high.
REQ-010 SHALL have port motor_up  output  1  drive shade toward closed.
REQ-011 SHALL have port motor_down  output  1  drive shade toward open.
REQ-012 SHALL have port position  output  4  current shade level.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a request completes.

Function
REQ-015 SHALL implement states IDLE, SETTLE, MOVE_UP and MOVE_DOWN.
REQ-016 SHALL drive wshade_ready high only in IDLE; a request is accepted on wshade_valid && wshade_ready, and the target is latched on that edge.
REQ-017 SHALL pulse done on the cycle after acceptance, with no motion, when the target equals position.
REQ-018 SHALL go directly to MOVE_UP when target > position and the last direction was up or none.
REQ-019 SHALL go directly to MOVE_DOWN when target < position and the last direction was down or none.
REQ-020 SHALL go to SETTLE for SETTLE_CYCLES cycles, motors off, when the required direction differs from the last direction, then enter the MOVE state.
REQ-021 SHALL assert motor_up only in MOVE_UP and motor_down only in MOVE_DOWN; both outputs are never high together.
REQ-022 SHALL change position by +/-1 every STEP_CYCLES cycles in a MOVE state, restarting the step timer at each step.
REQ-023 SHALL return to IDLE when position reaches the target: motors low and done high in the same cycle, and last direction recorded.
REQ-024 SHALL ignore wshade_valid while busy; no queuing, and the request is not acknowledged.
REQ-025 SHALL never step position past 15 or below 0.

Reset
REQ-026 SHALL force, while rst_n is low: state IDLE, motor_up = motor_down = 0, position = 0, last direction none, step timer 0, done = 0, busy = 0, wshade_ready = 0.
REQ-027 SHALL raise wshade_ready on the first clock edge after rst_n deasserts.
REQ-028 SHALL abort any move in progress when reset is asserted, with motors off immediately and no done pulse.

Configuration
REQ-029 SHALL provide macro SHADE_LIMIT_SW_EN.
REQ-030 With SHADE_LIMIT_SW_EN defined: limit_top high in MOVE_UP forces position to 15 and ends the request (IDLE, done pulse) on the next edge; limit_bottom high in MOVE_DOWN forces position to 0 and does likewise.
REQ-031 Without SHADE_LIMIT_SW_EN: limit_top and limit_bottom SHALL be ignored; the ports remain present.

Structure
REQ-032 SHALL place in package window_shade_pkg: the state enum, LEVEL_W = 4, SHADE_OPEN = 4'd0, SHADE_CLOSED = 4'd15, and the direction enum (NONE/UP/DOWN).
REQ-033 SHALL implement the step and settle down-counter as sub-module shade_step_timer, with load, value and expire signals.

Verification
REQ-034 SHALL cover, with STEP_CYCLES = 4: reset, then wshade = 3 accepted -> motor_up for 12 cycles, position 1,2,3, done pulses when position = 3.
REQ-035 SHALL cover: from position 3, request wshade = 1 -> 16 cycles in SETTLE with motors off, then motor_down for 8 cycles, position = 1, done.
REQ-036 SHALL cover: request equal to position (wshade = 1 at position 1) -> done on the next cycle, motors never asserted.
REQ-037 SHALL cover: wshade_valid with wshade = 9 while busy -> not accepted, the original move completes unchanged.
REQ-038 SHALL cover: with SHADE_LIMIT_SW_EN, moving 0 -> 15 with limit_top pulsed at position 6 -> position = 15, IDLE, done.
REQ-039 SHALL cover: rst_n asserted mid-move -> motors low asynchronously, position = 0, no done pulse.

Source files
------------

// File: rtl/window_shade_pkg.sv
// window_shade_pkg: shared types and constants for the window shade actuator.
//   state_e : controller states (IDLE, SETTLE, MOVE_UP, MOVE_DOWN)
//   dir_e   : last travel direction (NONE, UP, DOWN)
//   LEVEL_W, SHADE_OPEN, SHADE_CLOSED : shade level width and end stops
//   needs_settle() : true when a move must first pause for the reversal dead time
package window_shade_pkg;

    localparam int LEVEL_W = 4;
    localparam logic [LEVEL_W-1:0] SHADE_OPEN   = 4'd0;
    localparam logic [LEVEL_W-1:0] SHADE_CLOSED = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MOVE_UP,
        MOVE_DOWN
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } dir_e;

    // A reversal is only when a previous direction exists and differs.
    function automatic logic needs_settle(input dir_e last, input logic going_up);
        return (going_up && last == DOWN) || (!going_up && last == UP);
    endfunction

endpackage

// File: rtl/shade_step_timer.sv
// shade_step_timer: loadable down-counter used for both the per-level step
// period and the reversal dead time.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value this cycle (takes priority over counting)
//   load_value  : count to load; expire rises load_value+1 cycles after load
//   value       : current count
//   expire      : count has reached zero (holds at zero until reloaded)
module shade_step_timer #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - CNT_W'(1);
        end
    end

    assign expire = (value == '0);

endmodule

// File: rtl/window_shade_actuator.sv
// window_shade_actuator: drives a shade motor to a requested level (0 open,
// 15 closed), stepping one level every STEP_CYCLES cycles and inserting a
// SETTLE_CYCLES motor-off pause before any direction reversal.
//   clk, rst_n               : clock, asynchronous active-low reset
//   wshade, wshade_valid     : requested level and qualifier
//   wshade_ready             : request accepted on valid && ready (IDLE only)
//   limit_top, limit_bottom  : end-stop switches, active-high
//   motor_up, motor_down     : motor drive (never both high)
//   position                 : current shade level
//   busy                     : high outside IDLE
//   done                     : one-cycle pulse when a request completes
// Build option: define SHADE_LIMIT_SW_EN to let the limit switches end a move
// early and snap position to the end stop; otherwise they are ignored.
module window_shade_actuator
    import window_shade_pkg::*;
#(
    parameter int STEP_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LEVEL_W-1:0] wshade,
    input  logic               wshade_valid,
    output logic               wshade_ready,
    input  logic               limit_top,
    input  logic               limit_bottom,
    output logic               motor_up,
    output logic               motor_down,
    output logic [LEVEL_W-1:0] position,
    output logic               busy,
    output logic               done
);

    localparam int MAX_CYC = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state;
    dir_e               last_dir;
    logic [LEVEL_W-1:0] target;

    logic               accept;
    logic               going_up;
    logic               timer_load;
    logic [CNT_W-1:0]   timer_load_value;
    logic [CNT_W-1:0]   unused_timer_value;
    logic               timer_expire;

    assign accept   = wshade_valid && wshade_ready;
    assign going_up = (wshade > position);

`ifndef SHADE_LIMIT_SW_EN
    logic unused_limits;
    assign unused_limits = limit_top | limit_bottom;
`endif

    // The timer is reloaded on acceptance of a real move and on every
    // expiry while active, so each step period starts fresh.
    always_comb begin
        timer_load       = 1'b0;
        timer_load_value = STEP_LOAD;
        unique case (state)
            IDLE: begin
                if (accept && wshade != position) begin
                    timer_load = 1'b1;
                    if (needs_settle(last_dir, going_up))
                        timer_load_value = SETTLE_LOAD;
                end
            end
            SETTLE, MOVE_UP, MOVE_DOWN: timer_load = timer_expire;
            default: ;
        endcase
    end

    shade_step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (timer_load),
        .load_value(timer_load_value),
        .value     (unused_timer_value),
        .expire    (timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_dir     <= NONE;
            target       <= SHADE_OPEN;
            position     <= SHADE_OPEN;
            motor_up     <= 1'b0;
            motor_down   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wshade_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    wshade_ready <= 1'b1;
                    if (accept) begin
                        target <= wshade;
                        if (wshade == position) begin
                            done <= 1'b1;
                        end else begin
                            busy         <= 1'b1;
                            wshade_ready <= 1'b0;
                            if (needs_settle(last_dir, going_up)) begin
                                state <= SETTLE;
                            end else begin
                                state      <= going_up ? MOVE_UP : MOVE_DOWN;
                                motor_up   <= going_up;
                                motor_down <= !going_up;
                            end
                        end
                    end
                end
                SETTLE: begin
                    if (timer_expire) begin
                        state      <= (target > position) ? MOVE_UP : MOVE_DOWN;
                        motor_up   <= (target > position);
                        motor_down <= !(target > position);
                    end
                end
                MOVE_UP: begin
`ifdef SHADE_LIMIT_SW_EN
                    if (limit_top) begin
                        position     <= SHADE_CLOSED;
                        state        <= IDLE;
                        motor_up     <= 1'b0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        wshade_ready <= 1'b1;
                        last_dir     <= UP;
                    end else
`endif
                    if (timer_expire) begin
                        if (position != SHADE_CLOSED)
                            position <= position + 4'd1;
                        if (position == SHADE_CLOSED || position + 4'd1 == target) begin
                            state        <= IDLE;
                            motor_up     <= 1'b0;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            wshade_ready <= 1'b1;
                            last_dir     <= UP;
                        end
                    end
                end
                MOVE_DOWN: begin
`ifdef SHADE_LIMIT_SW_EN
                    if (limit_bottom) begin
                        position     <= SHADE_OPEN;
                        state        <= IDLE;
                        motor_down   <= 1'b0;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        wshade_ready <= 1'b1;
                        last_dir     <= DOWN;
                    end else
`endif
                    if (timer_expire) begin
                        if (position != SHADE_OPEN)
                            position <= position - 4'd1;
                        if (position == SHADE_OPEN || position - 4'd1 == target) begin
                            state        <= IDLE;
                            motor_down   <= 1'b0;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            wshade_ready <= 1'b1;
                            last_dir     <= DOWN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_shade_actuator.sv
// tb_window_shade_actuator: self-checking bench for window_shade_actuator with
// STEP_CYCLES = 4. Expected behaviour comes from a timeline model: a request
// from level p to level t takes S + |t-p|*STEP cycles (S = SETTLE on a
// reversal, else 0), the level advances once per completed STEP period, and
// done appears exactly at the end. Limit-switch behaviour follows the
// SHADE_LIMIT_SW_EN build option.
module tb_window_shade_actuator;

    localparam int STEP   = 4;
    localparam int SETTLE = 16;
`ifdef SHADE_LIMIT_SW_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] wshade = 4'd0;
    logic       wshade_valid = 1'b0;
    logic       limit_top = 1'b0;
    logic       limit_bottom = 1'b0;
    logic       wshade_ready, motor_up, motor_down, busy, done;
    logic [3:0] position;

    int checks = 0;
    int errors = 0;
    int m_pos  = 0;   // model level
    int m_dir  = 0;   // model last direction: 0 none, 1 up, 2 down

    always #5 clk = ~clk;

    window_shade_actuator #(.STEP_CYCLES(STEP), .SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wshade      (wshade),
        .wshade_valid(wshade_valid),
        .wshade_ready(wshade_ready),
        .limit_top   (limit_top),
        .limit_bottom(limit_bottom),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .position    (position),
        .busy        (busy),
        .done        (done)
    );

    // Issue one request and check every cycle until it completes.
    // poke: hold wshade_valid with wshade=9 while busy (must be ignored).
    // lim_at: level at which limit_top is pulsed during an up move (-1 = never).
    task automatic run_req(input int t, input bit poke, input int lim_at);
        int p0, n, s, nn, kl, steps, exp_pos;
        bit up, lim_hit;
        bit e_up, e_dn, e_done, e_busy, e_rdy;
        p0 = m_pos;
        up = (t > p0);
        n  = up ? t - p0 : p0 - t;
        s  = (n != 0 && ((up && m_dir == 2) || (!up && m_dir == 1))) ? SETTLE : 0;
        nn = s + n * STEP;
        kl = (lim_at >= 0) ? s + (lim_at - p0) * STEP : -1;
        lim_hit = LIM_EN && up && lim_at > p0 && lim_at < t;
        if (lim_hit) nn = kl + 1;

        @(posedge clk); #1;
        wshade = t[3:0];
        wshade_valid = 1'b1;
        for (int k = 0; k <= nn; k++) begin
            @(posedge clk); #1;
            wshade_valid = poke && (k < nn);
            if (poke) wshade = 4'd9;
            limit_top = (lim_at >= 0) && up && (k == kl);
            @(negedge clk);
            steps   = (k >= s) ? (k - s) / STEP : 0;
            exp_pos = up ? p0 + steps : p0 - steps;
            if (lim_hit && k == nn) exp_pos = 15;
            e_up   = (n != 0) && up  && (k >= s) && (k < nn);
            e_dn   = (n != 0) && !up && (k >= s) && (k < nn);
            e_done = (k == nn);
            e_busy = (k < nn);
            e_rdy  = !(k < nn);
            checks += 6;
            if (motor_up !== e_up) begin
                errors++; $display("FAIL motor_up t=%0d k=%0d got %b want %b", t, k, motor_up, e_up);
            end
            if (motor_down !== e_dn) begin
                errors++; $display("FAIL motor_down t=%0d k=%0d got %b want %b", t, k, motor_down, e_dn);
            end
            if (position !== exp_pos[3:0]) begin
                errors++; $display("FAIL position t=%0d k=%0d got %0d want %0d", t, k, position, exp_pos);
            end
            if (done !== e_done) begin
                errors++; $display("FAIL done t=%0d k=%0d got %b want %b", t, k, done, e_done);
            end
            if (busy !== e_busy) begin
                errors++; $display("FAIL busy t=%0d k=%0d got %b want %b", t, k, busy, e_busy);
            end
            if (wshade_ready !== e_rdy) begin
                errors++; $display("FAIL ready t=%0d k=%0d got %b want %b", t, k, wshade_ready, e_rdy);
            end
            if (k == nn) m_pos = exp_pos;
        end
        wshade_valid = 1'b0;
        limit_top = 1'b0;
        if (n != 0) m_dir = up ? 1 : 2;
        // done must be a single-cycle pulse and the level must hold
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_pulse_width t=%0d got %b want 0", t, done);
        end
        if (position !== m_pos[3:0]) begin
            errors++; $display("FAIL position_hold t=%0d got %0d want %0d", t, position, m_pos);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (motor_up !== 1'b0)     begin errors++; $display("FAIL rst_motor_up got %b want 0", motor_up); end
        if (motor_down !== 1'b0)   begin errors++; $display("FAIL rst_motor_down got %b want 0", motor_down); end
        if (position !== 4'd0)     begin errors++; $display("FAIL rst_position got %0d want 0", position); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got %b want 0", done); end
        if (wshade_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", wshade_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (wshade_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got %b want 1", wshade_ready); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL busy_after_rst got %b want 0", busy); end
        m_pos = 0;
        m_dir = 0;
    endtask

    task automatic test_move_up();    run_req(3, 1'b0, -1); endtask
    task automatic test_reverse();    run_req(1, 1'b0, -1); endtask
    task automatic test_equal();      run_req(1, 1'b0, -1); endtask
    task automatic test_busy_ignore(); run_req(7, 1'b1, -1); endtask

    task automatic test_limit();
        run_req(0, 1'b0, -1);
        run_req(15, 1'b0, 6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_req(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
    endtask

    task automatic test_reset_mid_move();
        int t;
        bit moving_down;
        t = (m_pos >= 8) ? 1 : 14;
        moving_down = (t < m_pos);
        @(posedge clk); #1;
        wshade = t[3:0];
        wshade_valid = 1'b1;
        @(posedge clk); #1;
        wshade_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        checks++;
        if ((moving_down ? motor_down : motor_up) !== 1'b1) begin
            errors++; $display("FAIL premid_motor got %b want 1", moving_down ? motor_down : motor_up);
        end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (motor_up !== 1'b0)     begin errors++; $display("FAIL mid_rst_motor_up got %b want 0", motor_up); end
        if (motor_down !== 1'b0)   begin errors++; $display("FAIL mid_rst_motor_down got %b want 0", motor_down); end
        if (position !== 4'd0)     begin errors++; $display("FAIL mid_rst_position got %0d want 0", position); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        if (wshade_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", wshade_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done cyc=%0d got %b want 0", i, done); end
        end
        rst_n = 1'b1;
        m_pos = 0;
        m_dir = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (done !== 1'b0) begin errors++; $display("FAIL post_rst_done cyc=%0d got %b want 0", i, done); end
            if (wshade_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready cyc=%0d got %b want 1", i, wshade_ready); end
        end
        run_req(2, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_move_up();
        test_reverse();
        test_equal();
        test_busy_ignore();
        test_limit();
        test_random();
        test_reset_mid_move();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case the design stalls the sequence.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
